// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the operation encodings, the memory-operation and alignment
// predicates, the FSM state enum and the store lane-mask helper.
package mem_access_unit_pkg;

    localparam int W_OPER = 4;
    localparam int W_ADDR = 32;

    // Code 0 is "not a memory operation"; loads and stores occupy 1..8.
    localparam logic [W_OPER-1:0] OP_NONE = 4'd0;
    localparam logic [W_OPER-1:0] OP_LB   = 4'd1;
    localparam logic [W_OPER-1:0] OP_LBU  = 4'd2;
    localparam logic [W_OPER-1:0] OP_LH   = 4'd3;
    localparam logic [W_OPER-1:0] OP_LHU  = 4'd4;
    localparam logic [W_OPER-1:0] OP_LW   = 4'd5;
    localparam logic [W_OPER-1:0] OP_SB   = 4'd6;
    localparam logic [W_OPER-1:0] OP_SH   = 4'd7;
    localparam logic [W_OPER-1:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [W_OPER-1:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0.
    function automatic logic misaligned(input logic [W_OPER-1:0] op,
                                        input logic [1:0]        lo);
        logic m;
        m = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = lo[0];
            OP_LW, OP_SW:         m = |lo;
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

    // Byte-lane mask at lane 0 for a store; loads write no lanes.
    function automatic logic [3:0] lane_mask(input logic [W_OPER-1:0] op);
        logic [3:0] m;
        case (op)
            OP_SB:   m = 4'h1;
            OP_SH:   m = 4'h3;
            OP_SW:   m = 4'hF;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// mem_lane_align: combinational lane steering for the memory access unit.
// Store side: byte-lane write enables and lane-replicated store data.
// Load side: selects the byte/halfword/word at lane 'off' and extends it.
// Ports:
//   oper      in  operation code
//   off       in  byte offset within the bus word
//   st_data   in  store source (low 32 bits of the store operand)
//   rdata     in  captured bus read data
//   we        out byte-lane write enables
//   wdata_rep out store data replicated across all lanes
//   load_data out extended load result (0 for stores)
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES)
) (
    input  logic [W_OPER-1:0] oper,
    input  logic [OFF_W-1:0]  off,
    input  logic [31:0]       st_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  we,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        we = LANES'(lane_mask(oper)) << off;

        wdata_rep = '0;
        case (oper)
            OP_SB:   wdata_rep = {LANES{st_data[7:0]}};
            OP_SH:   wdata_rep = {(LANES/2){st_data[15:0]}};
            OP_SW:   wdata_rep = {(LANES/4){st_data[31:0]}};
            default: wdata_rep = '0;
        endcase

        // Bring the addressed lane down to bit 0, then extend by size.
        shifted   = rdata >> {off, 3'b000};
        load_data = '0;
        case (oper)
            OP_LB:   load_data = DATA_W'($signed(shifted[7:0]));
            OP_LBU:  load_data = DATA_W'(shifted[7:0]);
            OP_LH:   load_data = DATA_W'($signed(shifted[15:0]));
            OP_LHU:  load_data = DATA_W'(shifted[15:0]);
            // On a 64-bit bus a word load is sign-extended.
            OP_LW:   load_data = DATA_W'($signed(shifted[31:0]));
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: issues one load/store on a simple data bus per
// pipeline request, with alignment checking and a bus timeout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/oper/addr/wdata pipeline request (held stable while stall=1)
//   stall                    pipeline must hold its inputs
//   resp_valid               one-cycle completion pulse
//   load_data, bus_err       response, valid with resp_valid
//   addr_err                 combinational misalignment flag
//   dbus_*                   data-bus request / response
//   dbg_state                current FSM state
// Bus handshake: dbus_en is held with stable dbus_we/addr/wdata from the
// first REQ cycle until the cycle in which dbus_ready=1; that cycle
// completes the transfer and dbus_rdata is sampled in it.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 16,
    localparam int LANES   = DATA_W / 8,
    localparam int OFF_W   = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [W_OPER-1:0] oper,
    input  logic [W_ADDR-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              addr_err,
    output logic              bus_err,
    output logic              dbus_en,
    output logic [LANES-1:0]  dbus_we,
    output logic [W_ADDR-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ready,
    output state_e            dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [W_OPER-1:0] oper_q, oper_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              accept;
    logic [LANES-1:0]  align_we;
    logic [DATA_W-1:0] align_load;

    // Stores never use more than a word, so only the low 32 bits are kept.
    logic [DATA_W-1:0] unused_wdata_hi;
    assign unused_wdata_hi = wdata;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .oper      (oper_q),
        .off       (addr_q[OFF_W-1:0]),
        .st_data   (wdata_q),
        .rdata     (rdata_q),
        .we        (align_we),
        .wdata_rep (dbus_wdata),
        .load_data (align_load)
    );

    always_comb begin
        addr_err = req_valid && is_mem_op(oper) && misaligned(oper, addr[1:0]);
        accept   = (state_q == ST_IDLE) && req_valid && is_mem_op(oper) && !addr_err;

        state_d   = state_q;
        oper_d    = oper_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        wait_d    = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    oper_d    = oper;
                    addr_d    = addr;
                    wdata_d   = wdata[31:0];
                    rdata_d   = '0;
                    bus_err_d = 1'b0;
                    wait_d    = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A ready arriving in the timeout cycle still completes normally.
                if (dbus_ready) begin
                    rdata_d   = dbus_rdata;
                    bus_err_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        rdata_d   = '0;
                        bus_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        stall      = accept || (state_q == ST_REQ);
        dbus_en    = (state_q == ST_REQ);
        dbus_we    = dbus_en ? align_we : '0;
        dbus_addr  = {addr_q[W_ADDR-1:OFF_W], {OFF_W{1'b0}}};
        resp_valid = (state_q == ST_DONE);
        bus_err    = resp_valid && bus_err_q;
        load_data  = (resp_valid && !bus_err_q) ? align_load : '0;
        dbg_state  = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            oper_q    <= OP_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            oper_q    <= oper_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

endmodule
